// File: rtl/axis_packet_filter_pkg.sv
// Shared types for the packet filter gate: gate FSM states and default sideband width.
package axis_packet_filter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } gate_state_t;

    // Default tuser layout is {dst, src, size}, 16 bits each.
    localparam int unsigned DEFAULT_USER_WIDTH = 48;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered AXIS slice.
// Ports: clk, rst (sync, active-high); s_valid/s_data/s_ready upstream side;
//        m_valid/m_data/m_ready downstream side (m_* are register outputs).
// Accepts a beat whenever fewer than two are held, so full throughput is
// sustained while m_ready stays high; m_data is the head entry, skid_q the second.
module axis_skid_buffer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    input  logic [W-1:0] s_data,
    output logic         s_ready,
    output logic         m_valid,
    output logic [W-1:0] m_data,
    input  logic         m_ready
);

    logic [1:0]   count;
    logic [1:0]   count_nxt;
    logic [W-1:0] skid_q;
    logic         push;
    logic         pop;

    assign s_ready = (count < 2'd2);
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    always_comb begin
        count_nxt = count + {1'b0, push} - {1'b0, pop};
    end

    // Head register refills from the skid entry first, then from the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= 2'd0;
            m_valid <= 1'b0;
            m_data  <= '0;
            skid_q  <= '0;
        end else begin
            count   <= count_nxt;
            m_valid <= (count_nxt != 2'd0);
            if (pop) begin
                if (count == 2'd2) begin
                    m_data <= skid_q;
                end else if (push) begin
                    m_data <= s_data;
                end
            end else if (push) begin
                if (count == 2'd0) begin
                    m_data <= s_data;
                end else begin
                    skid_q <= s_data;
                end
            end
        end
    end

endmodule

// File: rtl/axis_packet_filter_gate.sv
// Per-packet allow/deny gate between the classifier and egress AXIS.
// Ports: clk, rst (sync, active-high); s_axis_* ingress stream; dec_valid/
//        dec_allow/dec_ready decision push; cfg_bypass forwards everything
//        without consuming decisions; m_axis_* egress stream (registered via a
//        2-entry skid buffer); cnt_in/cnt_pass/cnt_drop packet counters;
//        dec_level number of queued decisions.
module axis_packet_filter_gate
    import axis_packet_filter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH = DEFAULT_USER_WIDTH,
    parameter int unsigned DEC_DEPTH  = 8,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]       s_axis_tkeep,
    input  logic                        s_axis_tlast,
    input  logic [USER_WIDTH-1:0]       s_axis_tuser,
    output logic                        s_axis_tready,
    input  logic                        dec_valid,
    input  logic                        dec_allow,
    output logic                        dec_ready,
    input  logic                        cfg_bypass,
    output logic                        m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]       m_axis_tkeep,
    output logic                        m_axis_tlast,
    output logic [USER_WIDTH-1:0]       m_axis_tuser,
    input  logic                        m_axis_tready,
    output logic [CNT_WIDTH-1:0]        cnt_in,
    output logic [CNT_WIDTH-1:0]        cnt_pass,
    output logic [CNT_WIDTH-1:0]        cnt_drop,
    output logic [$clog2(DEC_DEPTH):0]  dec_level
);

    localparam int unsigned AW = $clog2(DEC_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned SW = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

    gate_state_t          state;
    logic [DEC_DEPTH-1:0] dec_mem;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 fifo_head;
    logic                 dec_push;
    logic                 dec_pop;
    logic                 eff_allow;
    logic                 start_ok;
    logic                 in_hs;
    logic                 first_hs;
    logic                 skid_valid;
    logic                 skid_ready;
    logic [SW-1:0]        skid_in;
    logic [SW-1:0]        skid_out;

    // Decision FIFO status; pointers carry one extra bit to tell full from empty.
    assign dec_level  = wr_ptr - rd_ptr;
    assign fifo_empty = (dec_level == '0);
    assign fifo_full  = (dec_level == PW'(DEC_DEPTH));
    assign fifo_head  = dec_mem[rd_ptr[AW-1:0]];
    assign dec_ready  = !fifo_full;
    assign dec_push   = dec_valid && dec_ready;

    assign eff_allow  = cfg_bypass | fifo_head;
    assign start_ok   = cfg_bypass | !fifo_empty;

    // Ingress ready; a drop start needs no skid space since nothing is forwarded.
    always_comb begin
        s_axis_tready = 1'b0;
        case (state)
            IDLE:    s_axis_tready = start_ok && (eff_allow ? skid_ready : 1'b1);
            PASS:    s_axis_tready = skid_ready;
            DROP:    s_axis_tready = 1'b1;
            default: s_axis_tready = 1'b0;
        endcase
        if (rst) begin
            s_axis_tready = 1'b0;
        end
    end

    assign in_hs      = s_axis_tvalid && s_axis_tready;
    assign first_hs   = in_hs && (state == IDLE);
    assign dec_pop    = first_hs && !cfg_bypass;
    assign skid_valid = in_hs && ((state == PASS) || ((state == IDLE) && eff_allow));
    assign skid_in    = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser};

    // Gate FSM, decision pointers and packet counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_in   <= '0;
            cnt_pass <= '0;
            cnt_drop <= '0;
        end else begin
            if (dec_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (dec_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (in_hs) begin
                case (state)
                    IDLE: begin
                        if (!s_axis_tlast) begin
                            state <= eff_allow ? PASS : DROP;
                        end
                    end
                    default: begin
                        if (s_axis_tlast) begin
                            state <= IDLE;
                        end
                    end
                endcase
            end
            if (first_hs) begin
                cnt_in <= cnt_in + CNT_WIDTH'(1);
                if (eff_allow) begin
                    cnt_pass <= cnt_pass + CNT_WIDTH'(1);
                end else begin
                    cnt_drop <= cnt_drop + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Decision storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (dec_push && !rst) begin
            dec_mem[wr_ptr[AW-1:0]] <= dec_allow;
        end
    end

    axis_skid_buffer #(
        .W (SW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_valid (skid_valid),
        .s_data  (skid_in),
        .s_ready (skid_ready),
        .m_valid (m_axis_tvalid),
        .m_data  (skid_out),
        .m_ready (m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = skid_out;

endmodule

// File: tb/tb_axis_packet_filter_gate.sv
// Self-checking bench for axis_packet_filter_gate: packet-level model plus directed tests.
module tb_axis_packet_filter_gate;

    localparam int unsigned DW = 64;
    localparam int unsigned KW = 8;
    localparam int unsigned UW = 48;
    localparam int unsigned DD = 8;
    localparam int unsigned CW = 32;

    logic          clk;
    logic          rst;
    logic          s_axis_tvalid;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tlast;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tready;
    logic          dec_valid;
    logic          dec_allow;
    logic          dec_ready;
    logic          cfg_bypass;
    logic          m_axis_tvalid;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tready;
    logic [CW-1:0] cnt_in;
    logic [CW-1:0] cnt_pass;
    logic [CW-1:0] cnt_drop;
    logic [3:0]    dec_level;

    axis_packet_filter_gate #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .USER_WIDTH (UW),
        .DEC_DEPTH  (DD),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .dec_valid     (dec_valid),
        .dec_allow     (dec_allow),
        .dec_ready     (dec_ready),
        .cfg_bypass    (cfg_bypass),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .cnt_in        (cnt_in),
        .cnt_pass      (cnt_pass),
        .cnt_drop      (cnt_drop),
        .dec_level     (dec_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic [UW-1:0] u;
    } beat_t;

    bit          dec_q[$];
    beat_t       exp_out[$];
    bit          mdl_in_pkt;
    bit          mdl_allow;
    logic [CW-1:0] mdl_in, mdl_pass, mdl_drop;
    int          out_cnt = 0;
    bit          exp_rdy;
    bit          exp_dec_rdy;
    bit          allow_now;
    beat_t       nb;

    // Every negedge: check DUT against model, then advance model by this cycle's handshakes.
    always @(negedge clk) begin
        if (rst) begin
            dec_q.delete();
            exp_out.delete();
            mdl_in_pkt = 1'b0;
            mdl_allow  = 1'b0;
            mdl_in     = '0;
            mdl_pass   = '0;
            mdl_drop   = '0;
        end else begin
            exp_rdy   = 1'b0;
            allow_now = 1'b0;
            if (!mdl_in_pkt) begin
                if (cfg_bypass) begin
                    allow_now = 1'b1;
                    exp_rdy   = (exp_out.size() < 2);
                end else if (dec_q.size() > 0) begin
                    allow_now = dec_q[0];
                    exp_rdy   = allow_now ? (exp_out.size() < 2) : 1'b1;
                end
            end else begin
                exp_rdy = mdl_allow ? (exp_out.size() < 2) : 1'b1;
            end
            exp_dec_rdy = (dec_q.size() < DD);

            chk("s_tready", 64'(s_axis_tready), 64'(exp_rdy));
            chk("dec_ready", 64'(dec_ready), 64'(exp_dec_rdy));
            chk("dec_level", 64'(dec_level), 64'(dec_q.size()));
            chk("m_tvalid", 64'(m_axis_tvalid), 64'(exp_out.size() > 0));
            if (exp_out.size() > 0) begin
                chk("m_tdata", 64'(m_axis_tdata), 64'(exp_out[0].d));
                chk("m_tkeep", 64'(m_axis_tkeep), 64'(exp_out[0].k));
                chk("m_tlast", 64'(m_axis_tlast), 64'(exp_out[0].l));
                chk("m_tuser", 64'(m_axis_tuser), 64'(exp_out[0].u));
            end
            chk("cnt_in", 64'(cnt_in), 64'(mdl_in));
            chk("cnt_pass", 64'(cnt_pass), 64'(mdl_pass));
            chk("cnt_drop", 64'(cnt_drop), 64'(mdl_drop));

            if (exp_out.size() > 0 && m_axis_tready) begin
                void'(exp_out.pop_front());
                out_cnt++;
            end
            if (s_axis_tvalid && exp_rdy) begin
                if (!mdl_in_pkt) begin
                    if (!cfg_bypass) void'(dec_q.pop_front());
                    mdl_in = mdl_in + 1;
                    if (allow_now) mdl_pass = mdl_pass + 1;
                    else           mdl_drop = mdl_drop + 1;
                    mdl_allow = allow_now;
                end
                mdl_in_pkt = !s_axis_tlast;
                if (mdl_allow) begin
                    nb.d = s_axis_tdata;
                    nb.k = s_axis_tkeep;
                    nb.l = s_axis_tlast;
                    nb.u = s_axis_tuser;
                    exp_out.push_back(nb);
                end
            end
            if (dec_valid && exp_dec_rdy) dec_q.push_back(dec_allow);
        end
    end

    // ---------------- m_axis_tready pattern driver ----------------
    int rdy_mode = 0;
    int rdy_ph   = 0;
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rdy_ph = (rdy_ph + 1) % 3;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = (rdy_ph == 0);
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send_pkt(input int id, input int n, output int cyc);
        logic acc;
        cyc = 0;
        for (int b = 0; b < n; b++) begin
            acc           = 1'b0;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {32'(id), 32'(b)};
            s_axis_tkeep  = 8'hFF >> (b % 8);
            s_axis_tlast  = (b == n - 1);
            s_axis_tuser  = 48'(id * 1000 + b);
            while (!acc) begin
                @(negedge clk);
                acc = s_axis_tready;
                @(posedge clk);
                #1;
                cyc++;
                if (cyc > 500) begin
                    chk("send_timeout", 64'(1), 64'(0));
                    s_axis_tvalid = 1'b0;
                    return;
                end
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic push_dec(input logic a);
        logic acc;
        int   t;
        acc       = 1'b0;
        t         = 0;
        dec_valid = 1'b1;
        dec_allow = a;
        while (!acc && t < 500) begin
            @(negedge clk);
            acc = dec_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) chk("dec_push_timeout", 64'(0), 64'(1));
        dec_valid = 1'b0;
    endtask

    task automatic wait_out(input int base, input int n, input string name);
        int t;
        t = 0;
        while ((out_cnt - base) < n && t < 300) begin
            @(posedge clk);
            #2;
            t++;
        end
        repeat (3) @(posedge clk);
        #2;
        chk(name, 64'(out_cnt - base), 64'(n));
    endtask

    // ---------------- directed sequence ----------------
    int base;
    int cyc;
    int cyc2;

    initial begin
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        dec_valid     = 1'b0;
        dec_allow     = 1'b0;
        cfg_bypass    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_s_tready", 64'(s_axis_tready), 64'(0));
        chk("rst_dec_ready", 64'(dec_ready), 64'(1));
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));

        // 1: allowed 3-beat packet
        base = out_cnt;
        push_dec(1'b1);
        send_pkt(1, 3, cyc);
        wait_out(base, 3, "t1_beats_out");
        chk("t1_cnt_in", 64'(cnt_in), 64'(1));
        chk("t1_cnt_pass", 64'(cnt_pass), 64'(1));

        // 2: denied 4-beat packet, consumed at full rate
        base = out_cnt;
        push_dec(1'b0);
        chk("t2_level_1", 64'(dec_level), 64'(1));
        send_pkt(2, 4, cyc);
        chk("t2_cycles", 64'(cyc), 64'(4));
        wait_out(base, 0, "t2_no_beats");
        chk("t2_cnt_drop", 64'(cnt_drop), 64'(1));
        chk("t2_level_0", 64'(dec_level), 64'(0));
        chk("t2_cnt_in", 64'(cnt_in), 64'(2));

        // 3: allowed 8-beat packet under output backpressure
        base     = out_cnt;
        rdy_mode = 1;
        push_dec(1'b1);
        send_pkt(3, 8, cyc);
        wait_out(base, 8, "t3_beats_out");
        rdy_mode = 0;
        chk("t3_cnt_pass", 64'(cnt_pass), 64'(2));

        // 4: no decision queued blocks the start until one arrives
        base          = out_cnt;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {32'(4), 32'(0)};
        s_axis_tkeep  = 8'hFF;
        s_axis_tlast  = 1'b1;
        s_axis_tuser  = 48'(4000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t4_stalled", 64'(s_axis_tready), 64'(0));
            @(posedge clk);
            #1;
        end
        push_dec(1'b1);
        @(negedge clk);
        chk("t4_start", 64'(s_axis_tready), 64'(1));
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        wait_out(base, 1, "t4_beats_out");
        chk("t4_cnt_in", 64'(cnt_in), 64'(4));

        // 5: fill the decision FIFO, then push and pop together
        base = out_cnt;
        for (int i = 0; i < 8; i++) push_dec(1'b1);
        chk("t5_level_full", 64'(dec_level), 64'(8));
        chk("t5_dec_ready", 64'(dec_ready), 64'(0));
        send_pkt(50, 1, cyc);
        chk("t5_level_7", 64'(dec_level), 64'(7));
        fork
            push_dec(1'b1);
            send_pkt(51, 1, cyc2);
        join
        chk("t5_level_pushpop", 64'(dec_level), 64'(7));
        push_dec(1'b1);
        chk("t5_level_refill", 64'(dec_level), 64'(8));
        for (int i = 0; i < 8; i++) send_pkt(52 + i, 1, cyc);
        chk("t5_level_drained", 64'(dec_level), 64'(0));
        wait_out(base, 10, "t5_beats_out");
        chk("t5_cnt_in", 64'(cnt_in), 64'(14));

        // 6: bypass forwards regardless of a queued deny
        base = out_cnt;
        push_dec(1'b0);
        cfg_bypass = 1'b1;
        send_pkt(60, 2, cyc);
        send_pkt(61, 2, cyc);
        wait_out(base, 4, "t6_beats_out");
        chk("t6_level", 64'(dec_level), 64'(1));
        chk("t6_cnt_pass", 64'(cnt_pass), 64'(15));
        chk("t6_cnt_drop", 64'(cnt_drop), 64'(1));

        // reset mid-packet
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        s_axis_tkeep  = 8'hFF;
        s_axis_tdata  = {32'(70), 32'(0)};
        s_axis_tuser  = 48'(70000);
        @(posedge clk);
        #1;
        s_axis_tdata  = {32'(70), 32'(1)};
        @(posedge clk);
        #1;
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        cfg_bypass    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("r_s_tready", 64'(s_axis_tready), 64'(0));
        chk("r_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("r_m_tdata", 64'(m_axis_tdata), 64'(0));
        chk("r_m_tkeep", 64'(m_axis_tkeep), 64'(0));
        chk("r_m_tlast", 64'(m_axis_tlast), 64'(0));
        chk("r_m_tuser", 64'(m_axis_tuser), 64'(0));
        chk("r_cnt_in", 64'(cnt_in), 64'(0));
        chk("r_cnt_pass", 64'(cnt_pass), 64'(0));
        chk("r_cnt_drop", 64'(cnt_drop), 64'(0));
        chk("r_level", 64'(dec_level), 64'(0));
        chk("r_dec_ready", 64'(dec_ready), 64'(1));

        // after reset the next accepted beat starts a fresh packet
        base = out_cnt;
        push_dec(1'b1);
        send_pkt(80, 3, cyc);
        wait_out(base, 3, "r_beats_out");
        chk("r2_cnt_in", 64'(cnt_in), 64'(1));
        chk("r2_cnt_pass", 64'(cnt_pass), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
